// File: rtl/risc_toy_mem_stage.sv
// Memory stage of a toy RISC pipeline: forwards ALU results, performs aligned
// word loads/stores with a fixed read latency, and owns a single write-back slot.
module risc_toy_mem_stage #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EX_VALID,
   output logic        EX_READY,
   input  logic [1:0]  EX_OP,
   input  logic [31:0] EX_ALU_RESULT,
   input  logic [31:0] EX_STDATA,
   input  logic        EX_WEN,
   input  logic [4:0]  EX_WA,
   output logic        DREQ,
   output logic        DRW,
   output logic [29:0] DADDR,
   output logic [31:0] DWDATA,
   input  logic [31:0] DRDATA,
   output logic        WB_VALID,
   input  logic        WB_READY,
   output logic        WB_WEN,
   output logic [4:0]  WB_WA,
   output logic [31:0] WB_DATA,
   output logic        MISALIGN
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 32'd1);

   state_e      state_q;
   logic [2:0]  cnt_q;
   logic        dreq_q;
   logic        drw_q;
   logic [29:0] daddr_q;
   logic [31:0] dwdata_q;
   logic        ld_wen_q;
   logic [4:0]  ld_wa_q;
   logic        wb_valid_q;
   logic        wb_wen_q;
   logic [4:0]  wb_wa_q;
   logic [31:0] wb_data_q;
   logic        misalign_q;

   logic        accept_s;
   logic        is_mem_s;
   logic        aligned_s;
   logic        drain_s;

   // Ready only when idle and the write-back slot is empty or draining now
   assign EX_READY = (state_q == IDLE) && (!wb_valid_q || WB_READY);

   // Decode of the offered operation and of the write-back handshake
   always_comb begin
      accept_s  = EX_VALID && EX_READY;
      is_mem_s  = (EX_OP == OP_LOAD) || (EX_OP == OP_STORE);
      aligned_s = (EX_ALU_RESULT[1:0] == 2'b00);
      drain_s   = wb_valid_q && WB_READY;
   end

   // Stage FSM, memory request registers and the write-back slot
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         dreq_q     <= 1'b0;
         drw_q      <= 1'b0;
         daddr_q    <= 30'd0;
         dwdata_q   <= 32'd0;
         ld_wen_q   <= 1'b0;
         ld_wa_q    <= 5'd0;
         wb_valid_q <= 1'b0;
         wb_wen_q   <= 1'b0;
         wb_wa_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         // A fill later in this block overrides the drain (no bubble)
         if (drain_s) begin
            wb_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  if (!is_mem_s) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= EX_ALU_RESULT;
                     wb_wen_q   <= EX_WEN;
                     wb_wa_q    <= EX_WA;
                  end else if (!aligned_s) begin
                     misalign_q <= 1'b1;
                  end else begin
                     state_q  <= ACCESS;
                     dreq_q   <= 1'b1;
                     drw_q    <= (EX_OP == OP_STORE);
                     daddr_q  <= EX_ALU_RESULT[31:2];
                     ld_wen_q <= EX_WEN;
                     ld_wa_q  <= EX_WA;
                     if (EX_OP == OP_STORE) begin
                        dwdata_q <= EX_STDATA;
                     end
                  end
               end
            end
            ACCESS: begin
               dreq_q <= 1'b0;
               if (drw_q) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= CNT_INIT;
               end
            end
            WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q    <= IDLE;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= DRDATA;
                  wb_wen_q   <= ld_wen_q;
                  wb_wa_q    <= ld_wa_q;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               dreq_q  <= 1'b0;
            end
         endcase
      end
   end

   assign DREQ     = dreq_q;
   assign DRW      = drw_q;
   assign DADDR    = daddr_q;
   assign DWDATA   = dwdata_q;
   assign WB_VALID = wb_valid_q;
   assign WB_WEN   = wb_wen_q;
   assign WB_WA    = wb_wa_q;
   assign WB_DATA  = wb_data_q;
   assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_risc_toy_mem_stage.sv
// Bench for risc_toy_mem_stage: directed scenarios plus random traffic checked
// against a cycle-timeline reference model and a behavioural data memory.
module tb_risc_toy_mem_stage;

   localparam int LAT3 = 3;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid1 = 1'b0;
   logic        ex_valid3 = 1'b0;
   logic [1:0]  ex_op = 2'b00;
   logic [31:0] ex_alu = 32'd0;
   logic [31:0] ex_st = 32'd0;
   logic        ex_wen = 1'b0;
   logic [4:0]  ex_wa = 5'd0;
   logic        wb_ready = 1'b1;
   logic [31:0] dr1 = 32'd0;
   logic [31:0] dr3 = 32'd0;

   logic        rdy1, dreq1, drw1, wbv1, wbwen1, mis1;
   logic [29:0] daddr1;
   logic [31:0] dwd1, wbd1;
   logic [4:0]  wbwa1;
   logic        rdy3, dreq3, drw3, wbv3, wbwen3, mis3;
   logic [29:0] daddr3;
   logic [31:0] dwd3, wbd3;
   logic [4:0]  wbwa3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   risc_toy_mem_stage #(.RD_LAT(LAT1)) u_dut1 (
      .CLK(clk), .RST(rst), .EX_VALID(ex_valid1), .EX_READY(rdy1), .EX_OP(ex_op),
      .EX_ALU_RESULT(ex_alu), .EX_STDATA(ex_st), .EX_WEN(ex_wen), .EX_WA(ex_wa),
      .DREQ(dreq1), .DRW(drw1), .DADDR(daddr1), .DWDATA(dwd1), .DRDATA(dr1),
      .WB_VALID(wbv1), .WB_READY(wb_ready), .WB_WEN(wbwen1), .WB_WA(wbwa1),
      .WB_DATA(wbd1), .MISALIGN(mis1)
   );

   risc_toy_mem_stage #(.RD_LAT(LAT3)) u_dut3 (
      .CLK(clk), .RST(rst), .EX_VALID(ex_valid3), .EX_READY(rdy3), .EX_OP(ex_op),
      .EX_ALU_RESULT(ex_alu), .EX_STDATA(ex_st), .EX_WEN(ex_wen), .EX_WA(ex_wa),
      .DREQ(dreq3), .DRW(drw3), .DADDR(daddr3), .DWDATA(dwd3), .DRDATA(dr3),
      .WB_VALID(wbv3), .WB_READY(wb_ready), .WB_WEN(wbwen3), .WB_WA(wbwa3),
      .WB_DATA(wbd3), .MISALIGN(mis3)
   );

   // Contents of a never-written word; word 0x80 holds the directed load value
   function automatic logic [31:0] mem_default(input logic [9:0] a);
      if (a == 10'h080) return 32'hCAFE_F00D;
      return {a, 22'h2A_5A5A} ^ 32'h0F0F_3C3C;
   endfunction

   // Behavioural memories: DRDATA is junk except on the read-latency cycle
   bit [31:0] mem1 [1024];
   bit        wr1  [1024];
   bit [31:0] mem3 [1024];
   bit        wr3  [1024];
   int        left1 = 0;
   int        left3 = 0;
   logic [9:0] a1 = 10'd0;
   logic [9:0] a3 = 10'd0;

   always @(negedge clk) begin
      if (dreq1 && drw1) begin
         mem1[daddr1[9:0]] <= dwd1;
         wr1[daddr1[9:0]]  <= 1'b1;
      end
      if (dreq1 && !drw1) begin
         left1 <= LAT1;
         a1    <= daddr1[9:0];
      end else if (left1 > 0) begin
         left1 <= left1 - 1;
      end
      dr1 <= (left1 == 1) ? (wr1[a1] ? mem1[a1] : mem_default(a1)) : $urandom;
   end

   always @(negedge clk) begin
      if (dreq3 && drw3) begin
         mem3[daddr3[9:0]] <= dwd3;
         wr3[daddr3[9:0]]  <= 1'b1;
      end
      if (dreq3 && !drw3) begin
         left3 <= LAT3;
         a3    <= daddr3[9:0];
      end else if (left3 > 0) begin
         left3 <= left3 - 1;
      end
      dr3 <= (left3 == 1) ? (wr3[a3] ? mem3[a3] : mem_default(a3)) : $urandom;
   end

   // Reference model of u_dut3 as a timeline of cycle-stamped events
   int          cyc = 0;
   int          free_at = 0;
   int          dreq_cyc = -1;
   int          mis_cyc = -1;
   int          ld_due = -1;
   bit          slot_v = 1'b0;
   logic [31:0] slot_d = 32'd0;
   logic        slot_wen = 1'b0;
   logic [4:0]  slot_wa = 5'd0;
   logic [29:0] exp_addr = 30'd0;
   logic        exp_rw = 1'b0;
   logic [31:0] exp_wd = 32'd0;
   logic [31:0] ld_data = 32'd0;
   logic        ld_wen = 1'b0;
   logic [4:0]  ld_wa = 5'd0;
   bit [31:0]   ref_mem [1024];
   bit          ref_wr  [1024];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] op, input logic [31:0] alu,
                       input logic [31:0] st, input logic wen, input logic [4:0] wa,
                       input logic wbr);
      bit exp_rdy;
      bit is_dreq;
      logic [9:0] w;
      ex_valid3 = v; ex_op = op; ex_alu = alu; ex_st = st;
      ex_wen = wen; ex_wa = wa; wb_ready = wbr;
      @(negedge clk);
      exp_rdy = (cyc >= free_at) && (!slot_v || wbr);
      is_dreq = (cyc == dreq_cyc);
      chk("ex_ready", 32'(rdy3), 32'(exp_rdy));
      chk("wb_valid", 32'(wbv3), 32'(slot_v));
      if (slot_v) begin
         chk("wb_data", wbd3, slot_d);
         chk("wb_wen", 32'(wbwen3), 32'(slot_wen));
         chk("wb_wa", 32'(wbwa3), 32'(slot_wa));
      end
      chk("dreq", 32'(dreq3), 32'(is_dreq));
      if (is_dreq) begin
         chk("daddr", 32'(daddr3), 32'(exp_addr));
         chk("drw", 32'(drw3), 32'(exp_rw));
         if (exp_rw) chk("dwdata", dwd3, exp_wd);
      end
      chk("misalign", 32'(mis3), 32'(cyc == mis_cyc));
      if (slot_v && wbr) slot_v = 1'b0;
      if (cyc + 1 == ld_due) begin
         slot_v = 1'b1; slot_d = ld_data; slot_wen = ld_wen; slot_wa = ld_wa;
      end
      if (v && exp_rdy) begin
         if (op == 2'b01 || op == 2'b10) begin
            if (alu[1:0] != 2'b00) begin
               mis_cyc = cyc + 1;
            end else begin
               w = alu[11:2];
               dreq_cyc = cyc + 1; exp_addr = alu[31:2];
               exp_rw = (op == 2'b10); exp_wd = st;
               if (op == 2'b10) begin
                  ref_mem[w] = st; ref_wr[w] = 1'b1;
                  free_at = cyc + 2;
               end else begin
                  ld_due = cyc + 2 + LAT3; free_at = ld_due;
                  ld_data = ref_wr[w] ? ref_mem[w] : mem_default(w);
                  ld_wen = wen; ld_wa = wa;
               end
            end
         end else begin
            slot_v = 1'b1; slot_d = alu; slot_wen = wen; slot_wa = wa;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_valid1 = 1'b0; ex_valid3 = 1'b0;
      @(posedge clk); #1;
      chk("rst_dreq", 32'(dreq3), 32'd0);
      chk("rst_drw", 32'(drw3), 32'd0);
      chk("rst_daddr", 32'(daddr3), 32'd0);
      chk("rst_dwdata", dwd3, 32'd0);
      chk("rst_wb_valid", 32'(wbv3), 32'd0);
      chk("rst_wb_wen", 32'(wbwen3), 32'd0);
      chk("rst_wb_wa", 32'(wbwa3), 32'd0);
      chk("rst_wb_data", wbd3, 32'd0);
      chk("rst_misalign", 32'(mis3), 32'd0);
      chk("rst_wb_valid1", 32'(wbv1), 32'd0);
      rst = 1'b0;
      cyc++;
      free_at = 0; slot_v = 1'b0; dreq_cyc = -1; mis_cyc = -1; ld_due = -1;
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_alu;
      do_reset();

      // RD_LAT=1 load on the second instance
      ex_valid1 = 1'b1; ex_op = 2'b01; ex_alu = 32'h0000_0200; ex_wen = 1'b1;
      ex_wa = 5'd9; wb_ready = 1'b1;
      @(negedge clk);
      chk("l1_ready_t", 32'(rdy1), 32'd1);
      @(posedge clk); #1;
      ex_valid1 = 1'b0;
      chk("l1_dreq", 32'(dreq1), 32'd1);
      chk("l1_drw", 32'(drw1), 32'd0);
      chk("l1_daddr", 32'(daddr1), 32'h80);
      chk("l1_ready_busy", 32'(rdy1), 32'd0);
      @(posedge clk); #1;
      chk("l1_dreq_off", 32'(dreq1), 32'd0);
      chk("l1_wait_wbv", 32'(wbv1), 32'd0);
      @(posedge clk); #1;
      chk("l1_wbv", 32'(wbv1), 32'd1);
      chk("l1_wbdata", wbd1, 32'hCAFE_F00D);
      chk("l1_wbwa", 32'(wbwa1), 32'd9);
      @(posedge clk); #1;
      chk("l1_wbv_clr", 32'(wbv1), 32'd0);
      cyc += 4;

      // Pass
      step(1'b1, 2'b00, 32'h0000_1234, 32'd0, 1'b1, 5'd7, 1'b1);
      chk("pass_wbv", 32'(wbv3), 32'd1);
      chk("pass_wbdata", wbd3, 32'h0000_1234);
      chk("pass_wbwa", 32'(wbwa3), 32'd7);

      // Store
      step(1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1);
      chk("st_dreq", 32'(dreq3), 32'd1);
      chk("st_drw", 32'(drw3), 32'd1);
      chk("st_daddr", 32'(daddr3), 32'h40);
      chk("st_dwdata", dwd3, 32'hDEAD_BEEF);
      chk("st_no_wb", 32'(wbv3), 32'd0);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      chk("st_ready_t2", 32'(rdy3), 32'd1);

      // RD_LAT=3 load, with ignored offers while busy
      step(1'b1, 2'b01, 32'h0000_0200, 32'd0, 1'b1, 5'd3, 1'b1);
      chk("ld_dreq", 32'(dreq3), 32'd1);
      chk("ld_drw", 32'(drw3), 32'd0);
      chk("ld_daddr", 32'(daddr3), 32'h80);
      for (int i = 0; i < 4; i++) step(1'b1, 2'b00, 32'h0000_0BAD, 32'd0, 1'b1, 5'd1, 1'b1);
      chk("ld_wbv", 32'(wbv3), 32'd1);
      chk("ld_wbdata", wbd3, 32'hCAFE_F00D);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);

      // Misaligned load
      step(1'b1, 2'b01, 32'h0000_0102, 32'd0, 1'b1, 5'd4, 1'b1);
      chk("mis_pulse", 32'(mis3), 32'd1);
      chk("mis_dreq", 32'(dreq3), 32'd0);
      chk("mis_wbv", 32'(wbv3), 32'd0);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);

      // Backpressure on two back-to-back passes
      step(1'b1, 2'b00, 32'h0000_0011, 32'd0, 1'b1, 5'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold", wbd3, 32'h0000_0011);
         chk("bp_ready", 32'(rdy3), 32'd0);
         step(1'b1, 2'b00, 32'h0000_0022, 32'd0, 1'b1, 5'd2, 1'b0);
      end
      step(1'b1, 2'b00, 32'h0000_0022, 32'd0, 1'b1, 5'd2, 1'b1);
      chk("bp_second", wbd3, 32'h0000_0022);
      chk("bp_second_v", 32'(wbv3), 32'd1);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);

      // Reset while the load waits for memory
      step(1'b1, 2'b01, 32'h0000_0300, 32'd0, 1'b1, 5'd5, 1'b1);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);

      // Random traffic over a small word window so loads revisit stores
      for (int i = 0; i < 1500; i++) begin
         r_op = 2'($urandom_range(0, 3));
         if (r_op == 2'b01 || r_op == 2'b10) begin
            r_alu = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) r_alu[1:0] = 2'($urandom_range(1, 3));
         end else begin
            r_alu = $urandom;
         end
         step(1'($urandom_range(0, 3) != 0), r_op, r_alu, $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 2) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
